// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared single-port dmem, with a bounded bus lock for RMW.
// Optional address range check enabled by defining DMEM_ARB_RANGE_CHK_EN (adds p0_err/p1_err).
module dmem_arbiter #(
  parameter int LOCK_MAX  = 8,
  parameter int MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_we,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
`ifdef DMEM_ARB_RANGE_CHK_EN
  output logic        p0_err,
  output logic        p1_err,
`endif
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_we,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P0 = 2'd1, OWN_P1 = 2'd2} own_t;

  own_t        r_own, w_own_nxt;
  logic        r_last_gnt, w_last_nxt;   // 1 = port 1 was granted last
  logic [7:0]  r_lock_cnt, w_cnt_nxt;
  logic        w_gnt0, w_gnt1, w_rd0, w_rd1;
  logic [3:0]  w_we0, w_we1;
  logic [31:0] w_rval0, w_rval1;

  // Owner of a lock is the only candidate; otherwise a conflict goes to the port not granted last.
  assign w_gnt0 = !reset && p0_req &&
                  (r_own == OWN_P0 || (r_own == OWN_NONE && (!p1_req || r_last_gnt)));
  assign w_gnt1 = !reset && p1_req &&
                  (r_own == OWN_P1 || (r_own == OWN_NONE && (!p0_req || !r_last_gnt)));
  assign w_rd0  = w_gnt0 && (p0_we == 4'b0000);
  assign w_rd1  = w_gnt1 && (p1_we == 4'b0000);

`ifdef DMEM_ARB_RANGE_CHK_EN
  logic w_oor0, w_oor1, r_err0, r_err1;
  assign w_oor0  = (p0_addr >= 32'(MEM_BYTES));
  assign w_oor1  = (p1_addr >= 32'(MEM_BYTES));
  assign w_we0   = w_oor0 ? 4'b0000 : p0_we;
  assign w_we1   = w_oor1 ? 4'b0000 : p1_we;
  assign w_rval0 = w_oor0 ? 32'hDEADBEEF : drdata;
  assign w_rval1 = w_oor1 ? 32'hDEADBEEF : drdata;
  assign p0_err  = r_err0;
  assign p1_err  = r_err1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= w_gnt0 && w_oor0;
      r_err1 <= w_gnt1 && w_oor1;
    end
  end
`else
  assign w_we0   = p0_we;
  assign w_we1   = p1_we;
  assign w_rval0 = drdata;
  assign w_rval1 = drdata;
`endif

  always_comb begin
    w_own_nxt  = r_own;
    w_cnt_nxt  = r_lock_cnt;
    w_last_nxt = r_last_gnt;
    if (w_gnt0)      w_last_nxt = 1'b0;
    else if (w_gnt1) w_last_nxt = 1'b1;
    case (r_own)
      OWN_NONE: begin
        if (w_gnt0 && p0_lock) begin
          w_own_nxt = OWN_P0;
          w_cnt_nxt = 8'd1;
        end else if (w_gnt1 && p1_lock) begin
          w_own_nxt = OWN_P1;
          w_cnt_nxt = 8'd1;
        end
      end
      // Release marks the owner as last granted so the waiting port wins the next conflict.
      OWN_P0: begin
        if (!p0_lock || r_lock_cnt == 8'(LOCK_MAX)) begin
          w_own_nxt  = OWN_NONE;
          w_cnt_nxt  = 8'd0;
          w_last_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_lock_cnt + 8'd1;
        end
      end
      OWN_P1: begin
        if (!p1_lock || r_lock_cnt == 8'(LOCK_MAX)) begin
          w_own_nxt  = OWN_NONE;
          w_cnt_nxt  = 8'd0;
          w_last_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_lock_cnt + 8'd1;
        end
      end
      default: begin
        w_own_nxt = OWN_NONE;
        w_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own      <= OWN_NONE;
      r_lock_cnt <= 8'd0;
      r_last_gnt <= 1'b1;
    end else begin
      r_own      <= w_own_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_last_gnt <= w_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= 32'd0;
      p1_rdata  <= 32'd0;
    end else begin
      p0_rvalid <= w_rd0;
      p1_rvalid <= w_rd1;
      if (w_rd0) p0_rdata <= w_rval0;
      if (w_rd1) p1_rdata <= w_rval1;
    end
  end

  always_comb begin
    daddr  = 32'd0;
    dwdata = 32'd0;
    dwe    = 4'b0000;
    if (w_gnt0) begin
      daddr  = p0_addr;
      dwdata = p0_wdata;
      dwe    = w_we0;
    end else if (w_gnt1) begin
      daddr  = p1_addr;
      dwdata = p1_wdata;
      dwe    = w_we1;
    end
  end

  assign p0_gnt = w_gnt0;
  assign p1_gnt = w_gnt1;

  a_params: assert property (@(posedge clk)
    LOCK_MAX >= 1 && LOCK_MAX <= 255 && MEM_BYTES > 0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: scripted and random requesters, rule-level arbitration model, rvalid scoreboard.
module tb_dmem_arbiter;
  localparam int LOCK_MAX  = 8;
  localparam int MEM_BYTES = 16384;
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, lock, gnt, rvalid;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  we [2];
  logic [31:0] rdata [2];
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;
`ifdef DMEM_ARB_RANGE_CHK_EN
  logic [1:0]  err;
`endif

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(rst),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_we(we[0]), .p0_lock(lock[0]),
    .p0_gnt(gnt[0]), .p0_rvalid(rvalid[0]), .p0_rdata(rdata[0]),
`ifdef DMEM_ARB_RANGE_CHK_EN
    .p0_err(err[0]), .p1_err(err[1]),
`endif
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_we(we[1]), .p1_lock(lock[1]),
    .p1_gnt(gnt[1]), .p1_rvalid(rvalid[1]), .p1_rdata(rdata[1]),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // dmem fixture: combinational read, byte-enabled write at posedge, aliasing on [13:2]
  logic [31:0] fmem [4096];
  bit          fval [4096];
  always_comb drdata = fval[daddr[13:2]] ? fmem[daddr[13:2]] : init_word(int'(daddr[13:2]));
  always @(posedge clk)
    if (dwe != 4'b0000) begin
      fmem[daddr[13:2]] <= merge(fval[daddr[13:2]] ? fmem[daddr[13:2]] : init_word(int'(daddr[13:2])),
                                 dwdata, dwe);
      fval[daddr[13:2]] <= 1'b1;
    end

  typedef struct { int due; bit rd; bit err; logic [31:0] data; } exp_t;
  typedef struct { bit idle; logic [31:0] a; logic [31:0] d; logic [3:0] m; bit lk; } rq_t;

  exp_t        sq [2][$];
  rq_t         scr [2][$];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] rmem [4096];
  logic [31:0] exp_last [2];
  bit          preq [2], plk [2];
  logic [31:0] paddr [2], pwd [2];
  logic [3:0]  pwe [2];
  int          own, lcnt, last;
  bit          rnd_en = 1'b0;
  bit          ph4_on = 1'b0, ph4_seen0 = 1'b0;
  int          ph4_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return CHK && (a >= 32'(MEM_BYTES));
  endfunction

  task automatic s_rd(input int p, input logic [31:0] a, input bit lk);
    scr[p].push_back('{1'b0, a, 32'h0, 4'h0, lk});
  endtask
  task automatic s_wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    scr[p].push_back('{1'b0, a, d, m, 1'b0});
  endtask
  task automatic s_idle(input int p);
    scr[p].push_back('{1'b1, 32'h0, 32'h0, 4'h0, 1'b0});
  endtask

  task automatic gen();
    rq_t r;
    for (int p = 0; p < 2; p++) begin
      if (preq[p]) continue;
      if (scr[p].size() > 0) begin
        r = scr[p].pop_front();
        if (!r.idle) begin
          preq[p] = 1'b1; paddr[p] = r.a; pwd[p] = r.d; pwe[p] = r.m; plk[p] = r.lk;
        end
      end else if (rnd_en && $urandom_range(0, 99) < 70) begin
        preq[p]  = 1'b1;
        case ($urandom_range(0, 9))
          8:       paddr[p] = 32'h4000 + (32'($urandom_range(0, 4095)) << 2);
          9:       paddr[p] = 32'hFFFFFFFC;
          default: paddr[p] = 32'($urandom_range(0, 4095)) << 2;
        endcase
        pwd[p] = $urandom;
        pwe[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        plk[p] = ($urandom_range(0, 4) == 0);
      end
    end
  endtask

  // One bus cycle: drive held requests, predict grants by the arbitration rules, check, advance.
  task automatic step();
    bit g [2];
    logic [31:0] ea, ed;
    logic [3:0] ew;
    exp_t e;
    cyc++;
    gen();
    for (int p = 0; p < 2; p++) begin
      req[p] = preq[p]; lock[p] = preq[p] & plk[p];
      addr[p] = paddr[p]; wdata[p] = pwd[p]; we[p] = pwe[p];
    end
    g = '{1'b0, 1'b0};
    if (!rst) begin
      if (own >= 0)                 g[own] = preq[own];
      else if (preq[0] && preq[1])  g[1 - last] = 1'b1;
      else begin g[0] = preq[0]; g[1] = preq[1]; end
    end
    ea = 32'h0; ed = 32'h0; ew = 4'h0;
    for (int p = 0; p < 2; p++)
      if (g[p]) begin ea = paddr[p]; ed = pwd[p]; ew = oor(paddr[p]) ? 4'h0 : pwe[p]; end
    @(negedge clk);
    chk("p0_gnt", 32'(gnt[0]), 32'(g[0]));
    chk("p1_gnt", 32'(gnt[1]), 32'(g[1]));
    chk("daddr", daddr, ea);
    chk("dwdata", dwdata, ed);
    chk("dwe", 32'(dwe), 32'(ew));
    if (ph4_on && !ph4_seen0) begin
      if (gnt[0]) ph4_seen0 = 1'b1;
      else if (gnt[1]) ph4_run++;
    end
    for (int p = 0; p < 2; p++)
      if (g[p]) begin
        e.due = cyc + 1; e.rd = (pwe[p] == 4'h0); e.err = oor(paddr[p]);
        e.data = e.err ? 32'hDEADBEEF : rmem[paddr[p][13:2]];
        sq[p].push_back(e);
      end
    @(posedge clk);
    #1;
    if (rst) begin
      own = -1; lcnt = 0; last = 1;
    end else begin
      for (int p = 0; p < 2; p++)
        if (g[p]) begin
          last = p;
          if (pwe[p] != 4'h0 && !oor(paddr[p]))
            rmem[paddr[p][13:2]] = merge(rmem[paddr[p][13:2]], pwd[p], pwe[p]);
          preq[p] = 1'b0;
        end
      if (own < 0) begin
        for (int p = 0; p < 2; p++) if (g[p] && plk[p]) begin own = p; lcnt = 1; end
      end else if (!lock[own] || lcnt == LOCK_MAX) begin
        last = own; own = -1; lcnt = 0;
      end else begin
        lcnt++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  // Monitor: rvalid/rdata/err against the scoreboard every cycle.
  initial begin
    exp_t e;
    bit erv, eer;
    logic [31:0] edat;
    exp_last = '{32'h0, 32'h0};
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        erv = 1'b0; eer = 1'b0; edat = exp_last[p];
        if (sq[p].size() > 0 && sq[p][0].due <= cyc) begin
          e = sq[p].pop_front();
          if (e.due < cyc) chk("sb_stale", 32'(e.due), 32'(cyc));
          erv = e.rd; eer = e.err;
          if (e.rd) edat = e.data;
        end
        if (rvalid[p] || erv) chk(p == 0 ? "p0_rvalid" : "p1_rvalid", 32'(rvalid[p]), 32'(erv));
        chk(p == 0 ? "p0_rdata" : "p1_rdata", rdata[p], edat);
`ifdef DMEM_ARB_RANGE_CHK_EN
        if (err[p] || eer) chk(p == 0 ? "p0_err" : "p1_err", 32'(err[p]), 32'(eer));
`endif
        exp_last[p] = edat;
      end
      if (rst) exp_last = '{32'h0, 32'h0};
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) rmem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      preq[p] = 1'b0; plk[p] = 1'b0; paddr[p] = 32'h0; pwd[p] = 32'h0; pwe[p] = 4'h0;
    end
    own = -1; lcnt = 0; last = 1;
    do_reset(2);
    chk("rst_p0_rvalid", 32'(rvalid[0]), 32'h0);
    chk("rst_p1_rvalid", 32'(rvalid[1]), 32'h0);
    chk("rst_p0_rdata", rdata[0], 32'h0);
    chk("rst_p1_rdata", rdata[1], 32'h0);

    s_rd(0, 32'h10, 1'b0);                      // single read
    run(3);
    s_wr(0, 32'h20, 32'hAABBCCDD, 4'b0011);      // partial write then read back
    s_rd(0, 32'h20, 1'b0);
    run(4);

    do_reset(1);                                 // continuous conflict alternates
    for (int i = 0; i < 8; i++) begin
      s_rd(0, 32'(i) << 2, 1'b0);
      s_rd(1, 32'h100 + (32'(i) << 2), 1'b0);
    end
    run(18);

    do_reset(1);                                 // lock held to LOCK_MAX
    for (int i = 0; i < 12; i++) s_rd(1, 32'h200 + (32'(i) << 2), 1'b1);
    s_idle(0);
    for (int i = 0; i < 3; i++) s_rd(0, 32'h300 + (32'(i) << 2), 1'b0);
    ph4_on = 1'b1;
    run(20);
    ph4_on = 1'b0;
    chk("lock_run_p1", 32'(ph4_run), 32'(LOCK_MAX + 1));

    do_reset(1);                                 // voluntary release, waiter granted next cycle
    s_rd(0, 32'h40, 1'b1);
    s_idle(1);
    s_rd(1, 32'h44, 1'b0);
    run(5);

`ifdef DMEM_ARB_RANGE_CHK_EN
    s_wr(1, 32'h4000, 32'h11223344, 4'hF);       // out-of-range write and read
    s_rd(1, 32'h4000, 1'b0);
    s_rd(1, 32'h0, 1'b0);
    run(5);
`endif

    rnd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    rnd_en = 1'b0;
    run(30);
    chk("sb_drain", 32'(sq[0].size() + sq[1].size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
